mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single unified 16-bit-address / 32-bit-data memory port between the instruction-cache controller and the data-cache controller. Each cache presents a mem_req_type request and waits for a mem_data_type response. The arbiter grants one requester at a time, holds that transaction stable until memory signals ready, then routes the response back. The D-cache has fixed priority, and a starvation counter guarantees instruction-fetch progress.

Parameters:
STARVE_LIMIT, 4, consecutive D-cache grants allowed while an I-cache request waits before the I-cache is forced to win (legal range 1-15).

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset asserted)
i_mem_req  input  mem_req_type (50)  I-cache miss request; rw always 0
i_mem_data  output  mem_data_type (33)  response to I-cache
d_mem_req  input  mem_req_type (50)  D-cache request, read or write
d_mem_data  output  mem_data_type (33)  response to D-cache
mem_req  output  mem_req_type (50)  request to memory
mem_data  input  mem_data_type (33)  memory response
grant_i  output  1  I-cache transaction in flight
grant_d  output  1  D-cache transaction in flight

Behaviour:
- States: IDLE, SERVE_I, SERVE_D (arb_state_t).
- Reset (rst=0, asynchronous):
  - state=IDLE; mem_req all fields 0; hold register 0; starve_cnt=0; mask flags clear.
  - i_mem_data.ready=0, d_mem_data.ready=0, grant_i=0, grant_d=0.
  - A transaction in flight at reset is abandoned. Any mem_data.ready seen while in IDLE is ignored.
- IDLE arbitration, with eligible = valid AND not masked:
  - Only D eligible -> SERVE_D.
  - Only I eligible -> SERVE_I.
  - Both eligible -> SERVE_D, unless starve_cnt == STARVE_LIMIT, in which case SERVE_I.
  - Neither eligible -> stay in IDLE.
- Grant latching: on the IDLE->SERVE_x edge, the winner's addr/data/rw are latched into the hold register.
- mem_req while serving:
  - Driven from the hold register with valid=1 throughout SERVE_x.
  - Constant until completion, even if the requester's inputs change.
  - In IDLE, mem_req.valid=0.
- Latency: requester valid sampled in IDLE at edge N -> mem_req.valid=1 from cycle N+1. Minimum turnaround is 1 cycle.
- Completion:
  - In SERVE_x, when mem_data.ready=1, the granted requester's x_mem_data = mem_data (combinational, same cycle).
  - The other requester's ready stays 0, and its data is driven 0.
  - Next state is IDLE.
- Post-completion mask: the requester just served is masked for exactly the first IDLE cycle after completion. This prevents re-granting a stale valid.
- Starvation counter (4-bit):
  - Increments on each grant to D while i_mem_req.valid=1.
  - Clears on any grant to I.
  - Clears in IDLE when i_mem_req.valid=0.
  - Saturates at STARVE_LIMIT.
- Simultaneous events:
  - A new request arriving in the same cycle as ready is not considered until IDLE.
  - Requests arriving while in SERVE_x wait; no queueing beyond the requester holding valid.
- grant_i = (state==SERVE_I) and grant_d = (state==SERVE_D); they are registered-state decodes and never both 1.
- The requester's rw is passed through unchanged; the arbiter never alters addr or data.

Decomposition:
- Shared package mem_arb_def, alongside the existing icache_def, which holds mem_req_type, mem_data_type, cpu_req_type and cpu_result_type. mem_arb_def holds:
  - arb_state_t enum {IDLE, SERVE_I, SERVE_D}
  - the STARVE_DEFAULT constant
- One natural sub-module: mem_arb_priority.
  - Combinational winner selection plus the starvation counter register.
  - Inputs: i_valid_eff, d_valid_eff, idle, grant_taken.
  - Outputs: pick_i, pick_d.
- The FSM, hold register and response routing stay in mem_arbiter.

Test Plan:
- Reset mid-transaction:
  - Stimulus: I read of addr 16'h0040 granted; drop rst for 2 cycles; memory then returns ready with 32'hDEADBEEF.
  - Required: mem_req.valid=0 immediately on rst=0; i_mem_data.ready never 1; state IDLE.
- Single I read:
  - Stimulus: i_mem_req {addr=16'h0008, rw=0, valid=1}; memory ready 3 cycles later with 32'h12345678.
  - Required: mem_req.addr=16'h0008 with valid=1 from the next cycle; i_mem_data {data=32'h12345678, ready=1} in the ready cycle; d_mem_data.ready=0.
- Simultaneous requests:
  - Stimulus: in the same cycle, I addr 16'h0100 and D write {addr=16'h0200, data=32'hCAFEF00D, rw=1}.
  - Required: D served first (mem_req.rw=1, addr 16'h0200); after D ready, I served next (addr 16'h0100).
- Starvation, STARVE_LIMIT=4:
  - Stimulus: D continuously re-requests while I holds valid.
  - Required: exactly 4 D grants occur, then the 5th grant goes to I (grant_i=1); starve_cnt returns to 0.
- Stability and mask:
  - Stimulus: during SERVE_D, change d_mem_req.addr to 16'hFFFF; then, after completion, hold d valid for one extra cycle with no I request.
  - Required: mem_req.addr stays at the latched value until ready; no grant in the masked IDLE cycle; re-grant of D in the following cycle.

Source files
------------

// File: rtl/icache_def.sv
// Shared cache/memory bus types.
// Used by the caches and the memory arbiter.
package icache_def;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } mem_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } mem_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

endpackage

// File: rtl/mem_arbiter_pkg.sv
// Memory arbiter definitions.
// FSM encoding and starvation default.
package mem_arb_def;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  localparam int STARVE_DEFAULT = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Arbiter bus bundle: both cache ports,
// the memory port and grant status.
interface mem_arbiter_if;
  import icache_def::*;

  mem_req_type  i_mem_req;
  mem_data_type i_mem_data;
  mem_req_type  d_mem_req;
  mem_data_type d_mem_data;
  mem_req_type  mem_req;
  mem_data_type mem_data;
  logic         grant_i;
  logic         grant_d;

  modport master (
    output i_mem_req,
    output d_mem_req,
    output mem_data,
    input  i_mem_data,
    input  d_mem_data,
    input  mem_req,
    input  grant_i,
    input  grant_d
  );

  modport slave (
    input  i_mem_req,
    input  d_mem_req,
    input  mem_data,
    output i_mem_data,
    output d_mem_data,
    output mem_req,
    output grant_i,
    output grant_d
  );

endinterface

// File: rtl/mem_arb_priority.sv
// Winner selection: D-cache first, with a
// starvation counter forcing I-cache progress.
module mem_arb_priority
  import mem_arb_def::*;
#(
  parameter int STARVE_LIMIT = STARVE_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid_eff,
  input  logic d_valid_eff,
  input  logic idle,
  input  logic grant_taken,
  output logic pick_i,
  output logic pick_d
);

  logic [3:0] starve_cnt;
  logic       starved;

  assign starved = (starve_cnt == 4'(STARVE_LIMIT));

  assign pick_i = idle && i_valid_eff
               && (!d_valid_eff || starved);
  assign pick_d = idle && d_valid_eff
               && !(i_valid_eff && starved);

  // count D wins that bypass a waiting I request
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (grant_taken && pick_i) begin
      starve_cnt <= '0;
    end else if (grant_taken && pick_d && i_valid_eff) begin
      if (!starved) starve_cnt <= starve_cnt + 4'd1;
    end else if (idle && !i_valid_eff) begin
      starve_cnt <= '0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between I- and D-cache.
// Latches the winner and routes the response back.
module mem_arbiter
  import icache_def::*;
  import mem_arb_def::*;
#(
  parameter int STARVE_LIMIT = STARVE_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus
);

  arb_state_t  state;
  arb_state_t  state_nxt;
  logic [15:0] hold_addr;
  logic [31:0] hold_data;
  logic        hold_rw;
  logic        mask_i;
  logic        mask_d;
  logic        idle;
  logic        i_eff;
  logic        d_eff;
  logic        rdy;
  logic        pick_i;
  logic        pick_d;

  assign idle  = (state == IDLE);
  assign rdy   = bus.mem_data.ready;
  assign i_eff = bus.i_mem_req.valid && !mask_i;
  assign d_eff = bus.d_mem_req.valid && !mask_d;

  mem_arb_priority #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_prio (
    .clk         (clk),
    .rst         (rst),
    .i_valid_eff (i_eff),
    .d_valid_eff (d_eff),
    .idle        (idle),
    .grant_taken (idle && (i_eff || d_eff)),
    .pick_i      (pick_i),
    .pick_d      (pick_d)
  );

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // next state: grant from idle, release on ready
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (pick_d)      state_nxt = SERVE_D;
        else if (pick_i) state_nxt = SERVE_I;
      end
      SERVE_I,
      SERVE_D: begin
        if (rdy) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // latch winner; mask the just-served side once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_addr <= '0;
      hold_data <= '0;
      hold_rw   <= 1'b0;
      mask_i    <= 1'b0;
      mask_d    <= 1'b0;
    end else begin
      mask_i <= (state == SERVE_I) && rdy;
      mask_d <= (state == SERVE_D) && rdy;
      if (pick_d) begin
        hold_addr <= bus.d_mem_req.addr;
        hold_data <= bus.d_mem_req.data;
        hold_rw   <= bus.d_mem_req.rw;
      end else if (pick_i) begin
        hold_addr <= bus.i_mem_req.addr;
        hold_data <= bus.i_mem_req.data;
        hold_rw   <= bus.i_mem_req.rw;
      end
    end
  end

  // drive memory request and route response
  always_comb begin
    bus.mem_req    = '0;
    bus.i_mem_data = '0;
    bus.d_mem_data = '0;
    if (!idle) begin
      bus.mem_req.addr  = hold_addr;
      bus.mem_req.data  = hold_data;
      bus.mem_req.rw    = hold_rw;
      bus.mem_req.valid = 1'b1;
    end
    if (state == SERVE_I && rdy) bus.i_mem_data = bus.mem_data;
    if (state == SERVE_D && rdy) bus.d_mem_data = bus.mem_data;
  end

  assign bus.grant_i = (state == SERVE_I);
  assign bus.grant_d = (state == SERVE_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios
// then random traffic against a reference model.
module tb_mem_arbiter;
  import icache_def::*;
  import mem_arb_def::*;

  localparam int LIM = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(
    .STARVE_LIMIT(LIM)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // reference: who is served (0 none, 1 I, 2 D)
  int          serving;
  logic [15:0] h_addr;
  logic [31:0] h_data;
  logic        h_rw;
  bit          m_i, m_d;
  int          starve;
  bit          i_got, d_got;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    serving = 0;
    h_addr = '0; h_data = '0; h_rw = 1'b0;
    m_i = 0; m_d = 0; starve = 0;
  endtask

  task automatic model_step();
    bit iv, dv, ei, ed, rdy;
    iv  = bus.i_mem_req.valid;
    dv  = bus.d_mem_req.valid;
    rdy = bus.mem_data.ready;
    if (serving != 0) begin
      m_i = rdy && (serving == 1);
      m_d = rdy && (serving == 2);
      if (rdy) serving = 0;
    end else begin
      ei = iv && !m_i;
      ed = dv && !m_d;
      m_i = 0; m_d = 0;
      if (ed && !(ei && starve == LIM)) begin
        serving = 2;
        h_addr = bus.d_mem_req.addr;
        h_data = bus.d_mem_req.data;
        h_rw   = bus.d_mem_req.rw;
        if (iv) starve = (starve < LIM) ? starve + 1 : LIM;
        else    starve = 0;
      end else if (ei) begin
        serving = 1;
        h_addr = bus.i_mem_req.addr;
        h_data = bus.i_mem_req.data;
        h_rw   = bus.i_mem_req.rw;
        starve = 0;
      end else if (!iv) begin
        starve = 0;
      end
    end
  endtask

  task automatic compare();
    logic [49:0] er;
    logic [32:0] ei, ed;
    er = '0;
    if (serving != 0) er = {h_addr, h_data, h_rw, 1'b1};
    i_got = (serving == 1) && bus.mem_data.ready;
    d_got = (serving == 2) && bus.mem_data.ready;
    ei = i_got ? bus.mem_data : 33'd0;
    ed = d_got ? bus.mem_data : 33'd0;
    check("mem_req", 64'(bus.mem_req), 64'(er));
    check("i_data", 64'(bus.i_mem_data), 64'(ei));
    check("d_data", 64'(bus.d_mem_data), 64'(ed));
    check("grant_i", 64'(bus.grant_i), 64'(serving == 1));
    check("grant_d", 64'(bus.grant_d), 64'(serving == 2));
  endtask

  // inputs set at negedge; compare, then clock
  task automatic tick();
    #1 compare();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    bus.i_mem_req = '0;
    bus.d_mem_req = '0;
    bus.mem_data  = '0;
    model_reset();
    @(negedge clk);
    #1;
    check("rst_req", 64'(bus.mem_req), 64'd0);
    check("rst_gi", 64'(bus.grant_i), 64'd0);
    check("rst_gd", 64'(bus.grant_d), 64'd0);
    check("rst_ir", 64'(bus.i_mem_data.ready), 64'd0);
    check("rst_dr", 64'(bus.d_mem_data.ready), 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // reset in the middle of an I read
    bus.i_mem_req = '{addr: 16'h0040, data: 32'd0,
                      rw: 1'b0, valid: 1'b1};
    tick();
    check("rmt_gi_on", 64'(bus.grant_i), 64'd1);
    #2 rst = 1'b0;
    #1;
    check("rmt_valid", 64'(bus.mem_req.valid), 64'd0);
    check("rmt_gi_off", 64'(bus.grant_i), 64'd0);
    model_reset();
    bus.i_mem_req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    bus.mem_data = '{data: 32'hDEADBEEF, ready: 1'b1};
    #1;
    check("rmt_iready", 64'(bus.i_mem_data.ready), 64'd0);
    tick();
    check("rmt_idle", 64'(bus.grant_i), 64'd0);
    bus.mem_data = '0;

    // single I read, ready three cycles in
    bus.i_mem_req = '{addr: 16'h0008, data: 32'd0,
                      rw: 1'b0, valid: 1'b1};
    tick();
    check("ird_addr", 64'(bus.mem_req.addr), 64'h0008);
    check("ird_valid", 64'(bus.mem_req.valid), 64'd1);
    tick();
    tick();
    bus.mem_data = '{data: 32'h12345678, ready: 1'b1};
    #1;
    check("ird_resp", 64'(bus.i_mem_data), 64'h2468ACF1);
    check("ird_dready", 64'(bus.d_mem_data.ready), 64'd0);
    tick();
    bus.mem_data  = '0;
    bus.i_mem_req = '0;
    tick();

    // simultaneous: D first, then I
    bus.i_mem_req = '{addr: 16'h0100, data: 32'd0,
                      rw: 1'b0, valid: 1'b1};
    bus.d_mem_req = '{addr: 16'h0200, data: 32'hCAFEF00D,
                      rw: 1'b1, valid: 1'b1};
    tick();
    check("sim_d_addr", 64'(bus.mem_req.addr), 64'h0200);
    check("sim_d_rw", 64'(bus.mem_req.rw), 64'd1);
    check("sim_d_data", 64'(bus.mem_req.data), 64'hCAFEF00D);
    bus.mem_data = '{data: 32'h0, ready: 1'b1};
    tick();
    bus.mem_data  = '0;
    bus.d_mem_req = '0;
    tick();
    check("sim_i_gnt", 64'(bus.grant_i), 64'd1);
    check("sim_i_addr", 64'(bus.mem_req.addr), 64'h0100);
    bus.mem_data = '{data: 32'h55AA55AA, ready: 1'b1};
    tick();
    bus.mem_data  = '0;
    bus.i_mem_req = '0;
    tick();

    // D keeps re-requesting while I waits
    bus.i_mem_req = '{addr: 16'h1234, data: 32'd0,
                      rw: 1'b0, valid: 1'b1};
    bus.d_mem_req = '{addr: 16'h0444, data: 32'h1,
                      rw: 1'b0, valid: 1'b1};
    tick();
    check("stv_d_gnt", 64'(bus.grant_d), 64'd1);
    check("stv_cnt1", 64'(dut.u_prio.starve_cnt), 64'(starve));
    for (int g = 0; g < LIM && !bus.grant_i; g++) begin
      bus.mem_data = '{data: 32'h0, ready: 1'b1};
      tick();
      bus.mem_data = '0;
      tick();
    end
    check("stv_i_gnt", 64'(bus.grant_i), 64'd1);
    check("stv_cnt0", 64'(dut.u_prio.starve_cnt), 64'd0);
    bus.mem_data = '{data: 32'h77, ready: 1'b1};
    tick();
    bus.mem_data  = '0;
    bus.i_mem_req = '0;
    bus.d_mem_req = '0;
    repeat (3) tick();

    // held request is stable; stale valid masked once
    bus.d_mem_req = '{addr: 16'h0300, data: 32'h11111111,
                      rw: 1'b0, valid: 1'b1};
    tick();
    bus.d_mem_req.addr = 16'hFFFF;
    tick();
    check("stb_addr1", 64'(bus.mem_req.addr), 64'h0300);
    tick();
    check("stb_addr2", 64'(bus.mem_req.addr), 64'h0300);
    bus.mem_data = '{data: 32'h9, ready: 1'b1};
    tick();
    bus.mem_data = '0;
    check("msk_no_gnt", 64'(bus.grant_d), 64'd0);
    tick();
    check("msk_no_gnt2", 64'(bus.grant_d), 64'd0);
    check("msk_idle", 64'(bus.mem_req.valid), 64'd0);
    tick();
    check("msk_regnt", 64'(bus.grant_d), 64'd1);
    check("msk_addr", 64'(bus.mem_req.addr), 64'hFFFF);
    bus.mem_data = '{data: 32'h3, ready: 1'b1};
    tick();
    bus.mem_data  = '0;
    bus.d_mem_req = '0;
    tick();

    // random traffic
    i_got = 0;
    d_got = 0;
    for (int c = 0; c < 3000; c++) begin
      if (i_got) begin
        bus.i_mem_req.valid = 1'b0;
      end else if (!bus.i_mem_req.valid
                   && $urandom_range(0, 2) == 0) begin
        bus.i_mem_req.addr  = 16'($urandom);
        bus.i_mem_req.data  = $urandom;
        bus.i_mem_req.rw    = 1'b0;
        bus.i_mem_req.valid = 1'b1;
      end
      if (d_got) begin
        if ($urandom_range(0, 1) == 0)
          bus.d_mem_req.valid = 1'b0;
      end else if (!bus.d_mem_req.valid) begin
        if ($urandom_range(0, 2) == 0) begin
          bus.d_mem_req.addr  = 16'($urandom);
          bus.d_mem_req.data  = $urandom;
          bus.d_mem_req.rw    = 1'($urandom);
          bus.d_mem_req.valid = 1'b1;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        bus.d_mem_req.addr = 16'($urandom);
        bus.d_mem_req.data = $urandom;
      end
      bus.mem_data.data  = $urandom;
      bus.mem_data.ready = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
